dot_operand_streamer: RTL and testbench



---
 rtl/dot_stream_pkg.sv | 33 +++
 rtl/dot_operand_streamer_chunk_ram.sv | 32 +++
 rtl/dot_operand_streamer.sv | 187 ++++++++++++++++++
 tb/tb_dot_operand_streamer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_stream_pkg.sv
// Shared types and helpers for dot_operand_streamer: FSM state encoding,
// chunk-count arithmetic and partial-chunk lane masking.
package dot_stream_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Widest chunk the lane mask handles; narrower chunks are zero-extended.
  localparam int unsigned MAX_CHUNK_W = 1024;

  function automatic logic [32:0] ceil_div(input logic [31:0] total,
                                           input int unsigned no_of_units);
    logic [32:0] units_s;
    units_s = 33'(no_of_units);
    return ({1'b0, total} + units_s - 33'd1) / units_s;
  endfunction

  function automatic logic [MAX_CHUNK_W-1:0] mask_lanes(input logic [MAX_CHUNK_W-1:0] chunk,
                                                        input int unsigned element_width,
                                                        input int unsigned valid_lanes);
    logic [MAX_CHUNK_W-1:0] res_s;
    for (int unsigned i = 0; i < MAX_CHUNK_W; i++) begin
      res_s[i] = ((i / element_width) < valid_lanes) ? chunk[i] : 1'b0;
    end
    return res_s;
  endfunction

endpackage

// File: rtl/dot_operand_streamer_chunk_ram.sv
// Chunk buffer: one write port, one synchronous read port, write-first on
// an address collision so a same-cycle read sees the new chunk.
module chunk_ram
  import dot_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage write and registered read with write-through bypass.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/dot_operand_streamer.sv
// Streams A/B operand chunk pairs plus trailing zero chunks into
// vectorXvector_with_control. Define STREAM_STALL_COUNT_EN to add stall_count.
module dot_operand_streamer
  import dot_stream_pkg::*;
#(
  parameter int unsigned element_width = 32,
  parameter int unsigned no_of_units   = 8,
  parameter int unsigned DEPTH         = 64,
  parameter int unsigned FLUSH_CYCLES  = 2,
  localparam int unsigned CW = element_width * no_of_units,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [CW-1:0] wr_data,
  input  logic          start,
  input  logic [31:0]   total,
  input  logic          I_am_ready,
  output logic [CW-1:0] first_row_plus_additional,
  output logic [CW-1:0] vector2,
  output logic          outsider_read_now,
  output logic          busy,
  output logic          done,
  output logic          err
`ifdef STREAM_STALL_COUNT_EN
  ,
  output logic [31:0]   stall_count
`endif
);

  state_t                 state_r;
  logic [31:0]            total_r;
  logic [31:0]            flush_cnt_r;
  logic [31:0]            rem_s;
  logic [AW:0]            nchunk_r;
  logic [AW:0]            idx_r;
  logic [AW:0]            nchunk_s;
  logic [32:0]            nchunk_full_s;
  logic                   clamp_s;
  logic                   fire_s;
  logic                   wr_ok_s;
  logic [AW-1:0]          rd_addr_s;
  logic [CW-1:0]          a_q_s;
  logic [CW-1:0]          b_q_s;
  logic [MAX_CHUNK_W-1:0] a_m_s;
  logic [MAX_CHUNK_W-1:0] b_m_s;
  int unsigned            valid_lanes_s;

  assign busy          = (state_r != IDLE);
  assign fire_s        = outsider_read_now & I_am_ready;
  assign wr_ok_s       = wr_en & ~busy;
  assign nchunk_full_s = ceil_div(total, no_of_units);
  assign clamp_s       = (nchunk_full_s > 33'(DEPTH));
  assign nchunk_s      = clamp_s ? (AW+1)'(DEPTH) : nchunk_full_s[AW:0];

  // Read address: advance on a transfer so the next chunk is ready one cycle later.
  always_comb begin
    rd_addr_s = idx_r[AW-1:0];
    case (state_r)
      IDLE: begin
        rd_addr_s = '0;
      end
      STREAM: begin
        if (fire_s) begin
          rd_addr_s = idx_r[AW-1:0] + AW'(1);
        end else begin
          rd_addr_s = idx_r[AW-1:0];
        end
      end
      default: begin
        rd_addr_s = idx_r[AW-1:0];
      end
    endcase
  end

  chunk_ram #(.WIDTH(CW), .DEPTH(DEPTH)) u_ram_a (
    .clk   (clk),
    .we    (wr_ok_s & ~wr_sel),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr_s),
    .rdata (a_q_s)
  );

  chunk_ram #(.WIDTH(CW), .DEPTH(DEPTH)) u_ram_b (
    .clk   (clk),
    .we    (wr_ok_s & wr_sel),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr_s),
    .rdata (b_q_s)
  );

  // Lanes past the element count in the last chunk are zeroed in both operands.
  always_comb begin
    rem_s         = total_r - (32'(idx_r) * 32'(no_of_units));
    valid_lanes_s = (rem_s >= 32'(no_of_units)) ? no_of_units : rem_s;
    a_m_s         = mask_lanes(MAX_CHUNK_W'(a_q_s), element_width, valid_lanes_s);
    b_m_s         = mask_lanes(MAX_CHUNK_W'(b_q_s), element_width, valid_lanes_s);
  end

  // RAM output is held stable during stalls, so only state gates the data path.
  assign first_row_plus_additional = (state_r == STREAM) ? CW'(a_m_s) : '0;
  assign vector2                   = (state_r == STREAM) ? CW'(b_m_s) : '0;

  // Control FSM: chunk sequencing, flush, done pulse and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r           <= IDLE;
      total_r           <= 32'd0;
      nchunk_r          <= '0;
      idx_r             <= '0;
      flush_cnt_r       <= 32'd0;
      outsider_read_now <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            total_r     <= total;
            nchunk_r    <= nchunk_s;
            idx_r       <= '0;
            flush_cnt_r <= 32'd0;
            err         <= clamp_s;
            if (nchunk_s == '0) begin
              state_r           <= FLUSH;
              outsider_read_now <= 1'b1;
            end else begin
              state_r <= FETCH;
            end
          end
        end
        FETCH: begin
          outsider_read_now <= 1'b1;
          state_r           <= STREAM;
        end
        STREAM: begin
          if (fire_s) begin
            idx_r <= idx_r + (AW+1)'(1);
            if ((idx_r + (AW+1)'(1)) == nchunk_r) begin
              state_r <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (fire_s) begin
            if (flush_cnt_r == 32'(FLUSH_CYCLES - 1)) begin
              state_r           <= DONE;
              outsider_read_now <= 1'b0;
              done              <= 1'b1;
            end else begin
              flush_cnt_r <= flush_cnt_r + 32'd1;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
      if (wr_en && busy) begin
        err <= 1'b1;
      end
    end
  end

`ifdef STREAM_STALL_COUNT_EN
  // Stall cycles of the current stream; an ignored start does not clear it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= 32'd0;
    end else if ((state_r == IDLE) && start) begin
      stall_count <= 32'd0;
    end else if (outsider_read_now && !I_am_ready) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dot_operand_streamer.sv
// Self-checking bench for dot_operand_streamer: table-driven streams plus
// hand-written busy/reset/write-on-start sequences, checked by a scoreboard.
module tb_dot_operand_streamer;

  localparam int EW    = 32;
  localparam int NU    = 8;
  localparam int DEPTH = 64;
  localparam int FC    = 2;
  localparam int CW    = EW * NU;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic          wr_sel;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic          start;
  logic [31:0]   total;
  logic          I_am_ready;
  logic [CW-1:0] first_row_plus_additional;
  logic [CW-1:0] vector2;
  logic          outsider_read_now;
  logic          busy;
  logic          done;
  logic          err;
`ifdef STREAM_STALL_COUNT_EN
  logic [31:0]   stall_count;
`endif

  dot_operand_streamer #(
    .element_width (EW),
    .no_of_units   (NU),
    .DEPTH         (DEPTH),
    .FLUSH_CYCLES  (FC)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .wr_en                     (wr_en),
    .wr_sel                    (wr_sel),
    .wr_addr                   (wr_addr),
    .wr_data                   (wr_data),
    .start                     (start),
    .total                     (total),
    .I_am_ready                (I_am_ready),
    .first_row_plus_additional (first_row_plus_additional),
    .vector2                   (vector2),
    .outsider_read_now         (outsider_read_now),
    .busy                      (busy),
    .done                      (done),
    .err                       (err)
`ifdef STREAM_STALL_COUNT_EN
    ,
    .stall_count               (stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] a;
    logic [CW-1:0] b;
  } chunk_t;

  typedef struct {
    int     total;
    int     mode;      // 0: ready held high, 1: ready pattern 1,0,0
    int     exp_data;
    bit     exp_err;
    longint exp_dot;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            fires = 0;
  int            stalls = 0;
  int            done_cnt = 0;
  int            rise_cyc = -1;
  int            start_cyc, f0, s0, d0, rc;
  bit            prev_orn = 1'b0;
  longint        acc = 0;
  logic [CW-1:0] mem_a [DEPTH];
  logic [CW-1:0] mem_b [DEPTH];
  logic [CW-1:0] zero_chunk;
  logic [CW-1:0] new_chunk;
  chunk_t        exp_q [$];
  vec_t          vecs [7];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_chunk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic chunk_t exp_chunk(input int c, input int tot);
    chunk_t r;
    r.a = '0;
    r.b = '0;
    for (int l = 0; l < NU; l++) begin
      if (c * NU + l < tot) begin
        r.a[l*EW +: EW] = mem_a[c][l*EW +: EW];
        r.b[l*EW +: EW] = mem_b[c][l*EW +: EW];
      end
    end
    return r;
  endfunction

  task automatic push_expected(input int tot);
    int     n;
    chunk_t z;
    n = (tot + NU - 1) / NU;
    if (n > DEPTH) n = DEPTH;
    for (int c = 0; c < n; c++) exp_q.push_back(exp_chunk(c, tot));
    z.a = '0;
    z.b = '0;
    for (int k = 0; k < FC; k++) exp_q.push_back(z);
  endtask

  // Scoreboard sample, taken on the falling edge away from the active edge.
  task automatic sample();
    if (!reset) begin
      if (done) done_cnt++;
      if (outsider_read_now && !prev_orn && rise_cyc < 0) rise_cyc = cyc;
      if (outsider_read_now) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_chunk: got a=%h expected no chunk", first_row_plus_additional);
        end else begin
          check_chunk("a_chunk", first_row_plus_additional, exp_q[0].a);
          check_chunk("b_chunk", vector2, exp_q[0].b);
          if (I_am_ready) begin
            for (int l = 0; l < NU; l++) begin
              acc += longint'(first_row_plus_additional[l*EW +: EW]) * longint'(vector2[l*EW +: EW]);
            end
            void'(exp_q.pop_front());
            fires++;
          end else begin
            stalls++;
          end
        end
      end
    end
    prev_orn = outsider_read_now;
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic write_chunk(input bit sel, input int addr, input logic [CW-1:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = AW'(addr);
    wr_data = data;
    if (sel) mem_b[addr] = data;
    else     mem_a[addr] = data;
    step();
    wr_en = 1'b0;
  endtask

  task automatic kick(input int tot, input bit wr0, input logic [CW-1:0] wdata);
    start = 1'b1;
    total = 32'(tot);
    if (wr0) begin
      wr_en    = 1'b1;
      wr_sel   = 1'b0;
      wr_addr  = '0;
      wr_data  = wdata;
      mem_a[0] = wdata;
    end
    push_expected(tot);
    start_cyc = cyc;
    f0        = fires;
    s0        = stalls;
    d0        = done_cnt;
    acc       = 0;
    rc        = 0;
    rise_cyc  = -1;
    step();
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic finish_stream(input string name, input int mode, input int exp_data,
                               input bit exp_err, input longint exp_dot);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      I_am_ready = (mode == 0) ? 1'b1 : ((rc % 3) == 0);
      rc++;
      step();
      n++;
    end
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, n);
    end
    I_am_ready = 1'b1;
    repeat (3) step();
    check({name, "_done_pulses"}, longint'(done_cnt - d0), 1);
    check({name, "_busy"}, longint'(busy), 0);
    check({name, "_orn_idle"}, longint'(outsider_read_now), 0);
    check({name, "_err"}, longint'(err), longint'(exp_err));
    check({name, "_fires"}, longint'(fires - f0), longint'(exp_data + FC));
    check({name, "_leftover"}, longint'(exp_q.size()), 0);
    if (exp_data > 0) check({name, "_latency"}, longint'(rise_cyc - start_cyc), 2);
    check({name, "_dot"}, acc, exp_dot);
`ifdef STREAM_STALL_COUNT_EN
    check({name, "_stall_count"}, longint'(stall_count), longint'(stalls - s0));
`endif
  endtask

  initial begin
    int n;
    zero_chunk = '0;
    reset      = 1'b1;
    wr_en      = 1'b0;
    wr_sel     = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    start      = 1'b0;
    total      = 32'd0;
    I_am_ready = 1'b0;

    vecs[0] = '{20,  0, 3,  1'b0, 420};
    vecs[1] = '{20,  1, 3,  1'b0, 420};
    vecs[2] = '{0,   0, 0,  1'b0, 0};
    vecs[3] = '{513, 0, 64, 1'b1, 262656};
    vecs[4] = '{8,   1, 1,  1'b0, 72};
    vecs[5] = '{1,   0, 1,  1'b0, 2};
    vecs[6] = '{64,  0, 8,  1'b0, 4160};

    @(posedge clk);
    #1;
    step();
    check("rst_orn", longint'(outsider_read_now), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_err", longint'(err), 0);
    check_chunk("rst_a", first_row_plus_additional, zero_chunk);
    check_chunk("rst_b", vector2, zero_chunk);
`ifdef STREAM_STALL_COUNT_EN
    check("rst_stall_count", longint'(stall_count), 0);
`endif
    reset = 1'b0;
    step();

    for (int c = 0; c < DEPTH; c++) begin
      for (int l = 0; l < NU; l++) begin
        new_chunk[l*EW +: EW] = 32'(c * NU + l + 1);
      end
      write_chunk(1'b0, c, new_chunk);
      for (int l = 0; l < NU; l++) new_chunk[l*EW +: EW] = 32'd2;
      write_chunk(1'b1, c, new_chunk);
    end

    for (int i = 0; i < 7; i++) begin
      I_am_ready = 1'b1;
      kick(vecs[i].total, 1'b0, zero_chunk);
      finish_stream($sformatf("vec%0d", i), vecs[i].mode, vecs[i].exp_data,
                    vecs[i].exp_err, vecs[i].exp_dot);
    end

    // start and write while busy: both dropped, err raised
    I_am_ready = 1'b0;
    kick(20, 1'b0, zero_chunk);
    step();
    wr_en   = 1'b1;
    wr_sel  = 1'b0;
    wr_addr = AW'(1);
    wr_data = {CW{1'b1}};
    start   = 1'b1;
    total   = 32'd0;
    step();
    wr_en = 1'b0;
    start = 1'b0;
    check("busy_wr_err", longint'(err), 1);
    check("busy_still", longint'(busy), 1);
    finish_stream("busy_ignore", 0, 3, 1'b1, 420);
    I_am_ready = 1'b1;
    kick(20, 1'b0, zero_chunk);
    finish_stream("reread", 0, 3, 1'b0, 420);

    // asynchronous reset while chunk 1 is presented
    I_am_ready = 1'b1;
    kick(20, 1'b0, zero_chunk);
    n = 0;
    while ((fires - f0) < 1 && n < 20) begin
      step();
      n++;
    end
    check("pre_reset_fires", longint'(fires - f0), 1);
    I_am_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_orn", longint'(outsider_read_now), 0);
    check("arst_busy", longint'(busy), 0);
    check("arst_done", longint'(done), 0);
    check_chunk("arst_a", first_row_plus_additional, zero_chunk);
    check_chunk("arst_b", vector2, zero_chunk);
    exp_q.delete();
    d0 = done_cnt;
    repeat (3) step();
    check("arst_no_done", longint'(done_cnt - d0), 0);
    reset      = 1'b0;
    I_am_ready = 1'b1;
    step();
    kick(20, 1'b0, zero_chunk);
    finish_stream("after_reset", 0, 3, 1'b0, 420);

    // write to A[0] in the same cycle as start: stream sees new data
    for (int l = 0; l < NU; l++) new_chunk[l*EW +: EW] = 32'(100 + l);
    I_am_ready = 1'b1;
    kick(8, 1'b1, new_chunk);
    finish_stream("wr_on_start", 0, 1, 1'b0, 1656);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
